fractal_sync_node_ctrl: RTL
===========================

Name: fractal_sync_node_ctrl

Overview:
Controller for one node of the fractal synchronization tree. It arbitrates barrier requests from its two child ports: left/south (LS) and right/north (RN). Requests are tracked in a small pending table. A barrier either completes locally, or is merged into one request to the parent and its response is later broadcast back down to both children. It sits between the per-tile sync interfaces below and the next tree level above.

Parameters:
LVL_W, 4, width of the level field (hops remaining to the synchronizing node)
ID_W, 4, width of the barrier id
N_ENTRIES, 4, number of pending-table entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
ls_req_valid_i  in  1  LS child request valid
ls_req_ready_o  out  1  LS request accepted when valid&ready
ls_req_lvl_i  in  LVL_W  LS request level
ls_req_id_i  in  ID_W  LS barrier id
rn_req_valid_i / rn_req_ready_o / rn_req_lvl_i / rn_req_id_i  same as LS, RN child
up_req_valid_o  out  1  merged request to parent
up_req_ready_i  in  1  parent accepts
up_req_lvl_o  out  LVL_W  forwarded level
up_req_id_o  out  ID_W  forwarded id
up_rsp_valid_i  in  1  parent response (no backpressure)
up_rsp_id_i  in  ID_W  parent response id
ls_rsp_valid_o  out  1  one-cycle wake pulse to LS
ls_rsp_id_o  out  ID_W  wake id to LS
rn_rsp_valid_o / rn_rsp_id_o  same as LS, RN child
error_o  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset: every entry FREE; round-robin (RR) pointer = LS; all outputs 0.
- Entry fields: state, id, lvl, arrived mask (sd_e).
- Entry states:
  - FREE.
  - WAIT: one side has arrived; mask = SD_LEFT_SOUTH or SD_RIGHT_NORTH.
  - FWD: merged and sent upward; awaiting the parent response.
- Acceptance:
  - At most one child request is accepted per cycle.
  - If both children are valid and eligible, the RR pointer picks the winner. The pointer toggles after each grant made under contention.
  - Eligible means all of:
    - up_rsp_valid_i = 0;
    - a WAIT entry with the same id exists, or a FREE entry exists;
    - if the request would complete with lvl > 1, the up register is empty or draining this cycle.
  - A ready may depend on valid and id (combinational lookup).
- Match is on id only.
  - New id: allocate the lowest-index FREE entry as WAIT, storing id, lvl and the arrival side.
  - Matching WAIT entry from the opposite side completes the barrier:
    - lvl == 1: free the entry; at t+1, pulse ls_rsp_valid_o and rn_rsp_valid_o with that id.
    - lvl > 1: entry becomes FWD; at t+1, up_req_valid_o = 1 with lvl-1 and the id, held stable until up_req_ready_i.
  - Matching WAIT entry from the same side, or with a different lvl: request consumed; entry unchanged; error_o pulses at t+1.
  - Request with lvl == 0: consumed, error_o pulses at t+1.
  - Request whose id matches an FWD entry: consumed, error_o pulses at t+1.
- Parent response (up_rsp_valid_i):
  - Matching FWD entry: free it; at t+1, pulse both rsp outputs with the id.
  - No FWD match: error_o at t+1.
  - Has priority over child acceptance in that cycle (both readys = 0), so down-response outputs never conflict.
- Up register: one slot. It clears on valid&ready and may reload in the same cycle.
- Table full with no id match: the requesting child is stalled; no error.
- Reset mid-operation: all entries and the up register are dropped; no responses are emitted.

Decomposition:
- Shared package fractal_sync_pkg:
  - add fractal_sync_entry_e {ENT_FREE, ENT_WAIT, ENT_FWD};
  - reuse sd_e for the arrival mask.
- Sub-module fractal_sync_pend_table:
  - holds the N_ENTRIES entries;
  - provides id-match and first-free lookups and a single write port;
  - the controller keeps the arbitration, up register and response logic.

Test Plan:
- LS (lvl 1, id 3) at t0, then RN (lvl 1, id 3) at t2 -> at t3, ls_rsp_valid_o = rn_rsp_valid_o = 1 with id 3 for one cycle; entry returns to FREE.
- LS and RN (lvl 2, id 5) arrive in the same cycle -> LS granted first, RN one cycle later. up_req is then valid with lvl 1, id 5 and is held for 3 cycles while up_req_ready_i = 0. up_rsp id 5 -> both children are woken with id 5 one cycle later.
- Fill 4 entries with ids 0-3 from LS, then LS presents id 6 -> ls_req_ready_o = 0 until RN completes id 1, then id 6 is accepted into the freed entry.
- LS id 2 twice -> error_o pulse; the entry stays WAIT. up_rsp with unknown id 9 -> error_o pulse, no rsp outputs.
- up_rsp_valid_i in the same cycle as a completing child request -> child ready = 0 that cycle; request accepted the next cycle; the two wake pulses come out in separate cycles.
- Assert rst_i with 2 WAIT entries and up_req pending -> all outputs 0 next cycle. A later RN id matching the pre-reset LS allocates a new entry and produces no response.

Source files
------------

// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg
//   Shared types for the fractal synchronization tree.
//   sd_e                 : side/arrival mask (bit0 = left/south, bit1 = right/north)
//   fractal_sync_entry_e : pending-table entry state
//   side_sd()            : maps a child port select (0 = LS, 1 = RN) to its mask
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    SD_NONE        = 2'b00,
    SD_LEFT_SOUTH  = 2'b01,
    SD_RIGHT_NORTH = 2'b10,
    SD_BOTH        = 2'b11
  } sd_e;

  typedef enum logic [1:0] {
    ENT_FREE = 2'd0,
    ENT_WAIT = 2'd1,
    ENT_FWD  = 2'd2
  } fractal_sync_entry_e;

  function automatic sd_e side_sd(input logic rn);
    return rn ? SD_RIGHT_NORTH : SD_LEFT_SOUTH;
  endfunction

endpackage

// File: rtl/fractal_sync_pend_table.sv
// fractal_sync_pend_table
//   Pending-barrier table of N_ENTRIES entries {state, id, lvl, arrived mask}.
//   Ports:
//     clk_i, rst_i         : clock, synchronous active-high reset (all entries FREE)
//     lk_id_i[N_LK]        : ids to look up (combinational)
//     lk_hit_o/idx/state/lvl/mask : first non-FREE entry whose id matches
//     free_hit_o/free_idx_o: lowest-index FREE entry
//     we_i, widx_i, w*_i   : single write port, overwrites a whole entry
module fractal_sync_pend_table
  import fractal_sync_pkg::*;
#(
  parameter int LVL_W     = 4,
  parameter int ID_W      = 4,
  parameter int N_ENTRIES = 4,
  parameter int N_LK      = 3,
  parameter int IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_LK-1:0][ID_W-1:0]        lk_id_i,
  output logic [N_LK-1:0]                  lk_hit_o,
  output logic [N_LK-1:0][IDX_W-1:0]       lk_idx_o,
  output fractal_sync_entry_e [N_LK-1:0]   lk_state_o,
  output logic [N_LK-1:0][LVL_W-1:0]       lk_lvl_o,
  output sd_e [N_LK-1:0]                   lk_mask_o,
  output logic                             free_hit_o,
  output logic [IDX_W-1:0]                 free_idx_o,
  input  logic                             we_i,
  input  logic [IDX_W-1:0]                 widx_i,
  input  fractal_sync_entry_e              wstate_i,
  input  logic [ID_W-1:0]                  wid_i,
  input  logic [LVL_W-1:0]                 wlvl_i,
  input  sd_e                              wmask_i
);

  fractal_sync_entry_e    r_state [N_ENTRIES];
  logic [ID_W-1:0]        r_id    [N_ENTRIES];
  logic [LVL_W-1:0]       r_lvl   [N_ENTRIES];
  sd_e                    r_mask  [N_ENTRIES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int e = 0; e < N_ENTRIES; e++) begin
        r_state[e] <= ENT_FREE;
        r_id[e]    <= '0;
        r_lvl[e]   <= '0;
        r_mask[e]  <= SD_NONE;
      end
    end else if (we_i) begin
      r_state[widx_i] <= wstate_i;
      r_id[widx_i]    <= wid_i;
      r_lvl[widx_i]   <= wlvl_i;
      r_mask[widx_i]  <= wmask_i;
    end
  end

  // Live ids are unique (a known id never allocates a second entry),
  // so the first match is the only match.
  always_comb begin
    lk_hit_o   = '0;
    lk_idx_o   = '0;
    lk_state_o = {N_LK{ENT_FREE}};
    lk_lvl_o   = '0;
    lk_mask_o  = {N_LK{SD_NONE}};
    for (int k = 0; k < N_LK; k++) begin
      for (int e = 0; e < N_ENTRIES; e++) begin
        if (!lk_hit_o[k] && r_state[e] != ENT_FREE && r_id[e] == lk_id_i[k]) begin
          lk_hit_o[k]   = 1'b1;
          lk_idx_o[k]   = IDX_W'(e);
          lk_state_o[k] = r_state[e];
          lk_lvl_o[k]   = r_lvl[e];
          lk_mask_o[k]  = r_mask[e];
        end
      end
    end
  end

  always_comb begin
    free_hit_o = 1'b0;
    free_idx_o = '0;
    for (int e = 0; e < N_ENTRIES; e++) begin
      if (!free_hit_o && r_state[e] == ENT_FREE) begin
        free_hit_o = 1'b1;
        free_idx_o = IDX_W'(e);
      end
    end
  end

endmodule

// File: rtl/fractal_sync_node_ctrl.sv
// fractal_sync_node_ctrl
//   One node of the fractal sync tree. Arbitrates LS/RN child barrier
//   requests, completes barriers locally (lvl 1) or merges them into one
//   parent request (lvl > 1), and broadcasts parent responses to both children.
//   Ports:
//     clk_i, rst_i                         : clock, synchronous active-high reset
//     ls_req_*/rn_req_*                    : child requests (valid/ready, lvl, id)
//     up_req_*                             : merged request to parent (valid/ready)
//     up_rsp_valid_i/up_rsp_id_i           : parent response, no backpressure
//     ls_rsp_*/rn_rsp_*                    : one-cycle wake pulses to the children
//     error_o                              : one-cycle protocol error pulse
module fractal_sync_node_ctrl
  import fractal_sync_pkg::*;
#(
  parameter int LVL_W     = 4,
  parameter int ID_W      = 4,
  parameter int N_ENTRIES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ls_req_valid_i,
  output logic             ls_req_ready_o,
  input  logic [LVL_W-1:0] ls_req_lvl_i,
  input  logic [ID_W-1:0]  ls_req_id_i,
  input  logic             rn_req_valid_i,
  output logic             rn_req_ready_o,
  input  logic [LVL_W-1:0] rn_req_lvl_i,
  input  logic [ID_W-1:0]  rn_req_id_i,
  output logic             up_req_valid_o,
  input  logic             up_req_ready_i,
  output logic [LVL_W-1:0] up_req_lvl_o,
  output logic [ID_W-1:0]  up_req_id_o,
  input  logic             up_rsp_valid_i,
  input  logic [ID_W-1:0]  up_rsp_id_i,
  output logic             ls_rsp_valid_o,
  output logic [ID_W-1:0]  ls_rsp_id_o,
  output logic             rn_rsp_valid_o,
  output logic [ID_W-1:0]  rn_rsp_id_o,
  output logic             error_o
);

  localparam int IDX_W  = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int N_LK   = 3;
  localparam int LK_RSP = 2;  // lookups 0/1 are the LS/RN children

  // Table interface
  logic [N_LK-1:0][ID_W-1:0]      w_lk_id;
  logic [N_LK-1:0]                w_lk_hit;
  logic [N_LK-1:0][IDX_W-1:0]     w_lk_idx;
  fractal_sync_entry_e [N_LK-1:0] w_lk_state;
  logic [N_LK-1:0][LVL_W-1:0]     w_lk_lvl;
  sd_e [N_LK-1:0]                 w_lk_mask;
  logic                           w_free_hit;
  logic [IDX_W-1:0]               w_free_idx;
  logic                           w_we;
  logic [IDX_W-1:0]               w_widx;
  fractal_sync_entry_e            w_wstate;
  logic [ID_W-1:0]                w_wid;
  logic [LVL_W-1:0]               w_wlvl;
  sd_e                            w_wmask;

  // Per-side request view, index 0 = LS, 1 = RN
  logic [1:0]             w_req_valid;
  logic [1:0][LVL_W-1:0]  w_req_lvl;
  logic [1:0][ID_W-1:0]   w_req_id;
  logic [1:0]             w_wait_hit, w_cmpl, w_elig, w_gnt;
  logic                   w_up_free, w_sel;

  // Registered outputs / state
  logic             r_rr;        // 0 = LS wins next contention
  logic             r_up_valid;
  logic [LVL_W-1:0] r_up_lvl;
  logic [ID_W-1:0]  r_up_id;
  logic             r_dn_valid;
  logic [ID_W-1:0]  r_dn_id;
  logic             r_err;

  // Next-state from the action decode
  logic             w_dn_fire, w_up_load, w_err;
  logic [ID_W-1:0]  w_dn_id;

  assign w_req_valid = {rn_req_valid_i, ls_req_valid_i};
  assign w_req_lvl   = {rn_req_lvl_i, ls_req_lvl_i};
  assign w_req_id    = {rn_req_id_i, ls_req_id_i};
  assign w_lk_id     = {up_rsp_id_i, rn_req_id_i, ls_req_id_i};

  fractal_sync_pend_table #(
    .LVL_W(LVL_W), .ID_W(ID_W), .N_ENTRIES(N_ENTRIES), .N_LK(N_LK), .IDX_W(IDX_W)
  ) u_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lk_id_i    (w_lk_id),
    .lk_hit_o   (w_lk_hit),
    .lk_idx_o   (w_lk_idx),
    .lk_state_o (w_lk_state),
    .lk_lvl_o   (w_lk_lvl),
    .lk_mask_o  (w_lk_mask),
    .free_hit_o (w_free_hit),
    .free_idx_o (w_free_idx),
    .we_i       (w_we),
    .widx_i     (w_widx),
    .wstate_i   (w_wstate),
    .wid_i      (w_wid),
    .wlvl_i     (w_wlvl),
    .wmask_i    (w_wmask)
  );

  // Up slot can take a new merge if empty or emptying at this edge.
  assign w_up_free = !r_up_valid || up_req_ready_i;

  always_comb begin
    w_wait_hit = '0;
    w_cmpl     = '0;
    w_elig     = '0;
    for (int s = 0; s < 2; s++) begin
      w_wait_hit[s] = w_lk_hit[s] && (w_lk_state[s] == ENT_WAIT);
      // Completion needs the opposite side already waiting at the same level.
      w_cmpl[s] = w_wait_hit[s] && (w_lk_mask[s] == side_sd(s == 0))
                  && (w_lk_lvl[s] == w_req_lvl[s]) && (w_req_lvl[s] != '0);
      w_elig[s] = w_req_valid[s] && !up_rsp_valid_i
                  && (w_wait_hit[s] || w_free_hit)
                  && !(w_cmpl[s] && (w_req_lvl[s] > LVL_W'(1)) && !w_up_free);
    end
  end

  assign w_gnt[0] = w_elig[0] && (!w_elig[1] || !r_rr);
  assign w_gnt[1] = w_elig[1] && (!w_elig[0] ||  r_rr);
  assign w_sel    = w_gnt[1];

  assign ls_req_ready_o = w_gnt[0];
  assign rn_req_ready_o = w_gnt[1];

  // Parent response and child grant are mutually exclusive, so one
  // table write port and one down-response register suffice.
  always_comb begin
    w_we      = 1'b0;
    w_widx    = '0;
    w_wstate  = ENT_FREE;
    w_wid     = '0;
    w_wlvl    = '0;
    w_wmask   = SD_NONE;
    w_dn_fire = 1'b0;
    w_dn_id   = '0;
    w_up_load = 1'b0;
    w_err     = 1'b0;
    if (up_rsp_valid_i) begin
      if (w_lk_hit[LK_RSP] && w_lk_state[LK_RSP] == ENT_FWD) begin
        w_we      = 1'b1;
        w_widx    = w_lk_idx[LK_RSP];
        w_dn_fire = 1'b1;
        w_dn_id   = up_rsp_id_i;
      end else begin
        w_err = 1'b1;
      end
    end else if (|w_gnt) begin
      w_wid  = w_req_id[w_sel];
      w_wlvl = w_req_lvl[w_sel];
      if (w_req_lvl[w_sel] == '0) begin
        w_err = 1'b1;
      end else if (w_wait_hit[w_sel]) begin
        if (!w_cmpl[w_sel]) begin
          w_err = 1'b1;  // same side again or level mismatch
        end else if (w_req_lvl[w_sel] == LVL_W'(1)) begin
          w_we      = 1'b1;
          w_widx    = w_lk_idx[w_sel];
          w_dn_fire = 1'b1;
          w_dn_id   = w_req_id[w_sel];
        end else begin
          w_we      = 1'b1;
          w_widx    = w_lk_idx[w_sel];
          w_wstate  = ENT_FWD;
          w_wmask   = SD_BOTH;
          w_up_load = 1'b1;
        end
      end else if (w_lk_hit[w_sel]) begin
        w_err = 1'b1;  // id already forwarded upward
      end else begin
        w_we     = 1'b1;
        w_widx   = w_free_idx;
        w_wstate = ENT_WAIT;
        w_wmask  = side_sd(w_sel);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr       <= 1'b0;
      r_up_valid <= 1'b0;
      r_up_lvl   <= '0;
      r_up_id    <= '0;
      r_dn_valid <= 1'b0;
      r_dn_id    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (&w_elig) r_rr <= ~r_rr;
      if (w_up_load) begin
        r_up_valid <= 1'b1;
        r_up_lvl   <= w_req_lvl[w_sel] - LVL_W'(1);
        r_up_id    <= w_req_id[w_sel];
      end else if (up_req_ready_i) begin
        r_up_valid <= 1'b0;
      end
      r_dn_valid <= w_dn_fire;
      r_dn_id    <= w_dn_id;
      r_err      <= w_err;
    end
  end

  assign up_req_valid_o = r_up_valid;
  assign up_req_lvl_o   = r_up_lvl;
  assign up_req_id_o    = r_up_id;
  assign ls_rsp_valid_o = r_dn_valid;
  assign ls_rsp_id_o    = r_dn_id;
  assign rn_rsp_valid_o = r_dn_valid;
  assign rn_rsp_id_o    = r_dn_id;
  assign error_o        = r_err;

  // Response-lookup level/mask are not needed by the control path.
  logic w_unused;
  assign w_unused = ^{w_lk_lvl[LK_RSP], w_lk_mask[LK_RSP]};

endmodule
